// File: rtl/fetch_pkg.sv
// Shared fetch types, opcode encodings and predecode helpers.
// Used by FS2 and its per-slot predecoders.
package fetch_pkg;

  localparam int FETCH_WIDTH = 4;
  localparam int SIZE_PC = 32;
  localparam int INST_WIDTH = 64;

  localparam logic [7:0] OP_J = 8'h02;
  localparam logic [7:0] OP_JAL = 8'h03;
  localparam logic [7:0] OP_BEQ = 8'h04;
  localparam logic [7:0] OP_BNE = 8'h05;
  localparam logic [7:0] OP_BLEZ = 8'h06;
  localparam logic [7:0] OP_BGTZ = 8'h07;
  localparam logic [7:0] OP_JR = 8'h08;
  localparam logic [7:0] OP_JALR = 8'h09;
  localparam logic [7:0] OP_RET = 8'h0A;

  typedef enum logic [1:0] {
    BR_RET = 2'b00,
    BR_CALL = 2'b01,
    BR_JUMP = 2'b10,
    BR_COND = 2'b11
  } br_type_t;

  typedef struct packed {
    logic is_cti;
    br_type_t br_type;
    logic is_direct;
  } predec_t;

  typedef struct packed {
    logic valid;
    logic [FETCH_WIDTH*INST_WIDTH-1:0] inst;
    logic [SIZE_PC-1:0] pc;
    logic [FETCH_WIDTH-1:0] btb_hit;
    logic [FETCH_WIDTH-1:0] pred;
    logic [FETCH_WIDTH*SIZE_PC-1:0] target;
    logic [SIZE_PC-1:0] ras;
  } fs2_reg_t;

  function automatic predec_t predecode(
    input logic [INST_WIDTH-1:0] inst
  );
    predec_t p;
    p = '{1'b0, BR_RET, 1'b0};
    case (inst[63:56])
      OP_J: p = '{1'b1, BR_JUMP, 1'b1};
      OP_JAL: p = '{1'b1, BR_CALL, 1'b1};
      OP_JR: p = '{1'b1, BR_JUMP, 1'b0};
      OP_JALR: p = '{1'b1, BR_CALL, 1'b0};
      OP_RET: p = '{1'b1, BR_RET, 1'b0};
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
        p = '{1'b1, BR_COND, 1'b1};
      default: ;
    endcase
    return p;
  endfunction

  function automatic logic [SIZE_PC-1:0] cond_target(
    input logic [SIZE_PC-1:0] pc,
    input logic [INST_WIDTH-1:0] inst
  );
    return pc + 32'd8
      + {{13{inst[15]}}, inst[15:0], 3'b000};
  endfunction

  function automatic logic [SIZE_PC-1:0] jump_target(
    input logic [SIZE_PC-1:0] pc,
    input logic [INST_WIDTH-1:0] inst
  );
    return {pc[31:29], inst[25:0], 3'b000};
  endfunction

endpackage

// File: rtl/fetch_stage2_if.sv
// FS1 -> FS2 bundle, FS2 -> Decode bundle and
// ID-stage redirect signals back to FS1.
interface fetch_stage2_if;
  import fetch_pkg::*;

  logic fs1Ready_i;
  logic [FETCH_WIDTH*INST_WIDTH-1:0] instBundle_i;
  logic [SIZE_PC-1:0] pc_i;
  logic [FETCH_WIDTH-1:0] btbHit_i;
  logic [FETCH_WIDTH-1:0] prediction_i;
  logic [FETCH_WIDTH*SIZE_PC-1:0] targetAddr_i;
  logic [SIZE_PC-1:0] addrRAS_CP_i;

  logic flagRecoverID_o;
  logic [SIZE_PC-1:0] targetAddrID_o;
  logic flagCallID_o;
  logic [SIZE_PC-1:0] callPCID_o;
  logic flagRtrID_o;
  logic fs2Valid_o;
  logic [FETCH_WIDTH-1:0] instValid_o;
  logic [FETCH_WIDTH*INST_WIDTH-1:0] instBundle_o;
  logic [SIZE_PC-1:0] pc_o;
  logic [FETCH_WIDTH-1:0] predTaken_o;
  logic [FETCH_WIDTH*SIZE_PC-1:0] predTarget_o;
  logic [2*FETCH_WIDTH-1:0] brType_o;
  logic [FETCH_WIDTH-1:0] isCti_o;
  logic [2:0] ctiCount_o;

  modport master (
    output fs1Ready_i, instBundle_i, pc_i,
    output btbHit_i, prediction_i,
    output targetAddr_i, addrRAS_CP_i,
    input flagRecoverID_o, targetAddrID_o,
    input flagCallID_o, callPCID_o,
    input flagRtrID_o, fs2Valid_o,
    input instValid_o, instBundle_o, pc_o,
    input predTaken_o, predTarget_o,
    input brType_o, isCti_o, ctiCount_o
  );

  modport slave (
    input fs1Ready_i, instBundle_i, pc_i,
    input btbHit_i, prediction_i,
    input targetAddr_i, addrRAS_CP_i,
    output flagRecoverID_o, targetAddrID_o,
    output flagCallID_o, callPCID_o,
    output flagRtrID_o, fs2Valid_o,
    output instValid_o, instBundle_o, pc_o,
    output predTaken_o, predTarget_o,
    output brType_o, isCti_o, ctiCount_o
  );

endinterface

// File: rtl/fs2_predecode.sv
// Per-slot predecoder: control type, directness and
// statically computable target for one instruction.
module fs2_predecode
  import fetch_pkg::*;
(
  input logic [INST_WIDTH-1:0] inst,
  input logic [SIZE_PC-1:0] pc,
  output logic is_cti,
  output br_type_t br_type,
  output logic is_direct,
  output logic [SIZE_PC-1:0] target
);

  predec_t p;

  assign p = predecode(inst);
  assign is_cti = p.is_cti;
  assign br_type = p.br_type;
  assign is_direct = p.is_direct;
  assign target = (p.br_type == BR_COND)
    ? cond_target(pc, inst)
    : jump_target(pc, inst);

endmodule

// File: rtl/fetch_stage2.sv
// Fetch stage 2: registers the FS1 bundle, checks BTB
// decisions against predecode and redirects FS1.
module fetch_stage2
  import fetch_pkg::*;
(
  input logic clk,
  input logic reset,
  input logic flush_i,
  input logic stall_i,
  fetch_stage2_if.slave bus
);

  fs2_reg_t r;
  logic squash;

  logic [SIZE_PC-1:0] slot_pc [FETCH_WIDTH];
  logic cti [FETCH_WIDTH];
  br_type_t br [FETCH_WIDTH];
  logic dir [FETCH_WIDTH];
  logic [SIZE_PC-1:0] dtgt [FETCH_WIDTH];

  logic rec, call, rtr, done, hit, fs1_taken;
  logic [SIZE_PC-1:0] tgt, cpc;
  logic [FETCH_WIDTH-1:0] taken, live, iv, cti_v;
  logic [SIZE_PC-1:0] fin_tgt [FETCH_WIDTH];
  logic en;

  // Squash drops the bundle FS1 fetched down the wrong path.
  always_ff @(posedge clk) begin
    if (reset) begin
      r <= '0;
      squash <= 1'b0;
    end else if (flush_i) begin
      r.valid <= 1'b0;
      squash <= 1'b0;
    end else begin
      squash <= bus.flagRecoverID_o;
      if (!stall_i) begin
        r <= '{
          valid: bus.fs1Ready_i & ~squash,
          inst: bus.instBundle_i,
          pc: bus.pc_i,
          btb_hit: bus.btbHit_i,
          pred: bus.prediction_i,
          target: bus.targetAddr_i,
          ras: bus.addrRAS_CP_i
        };
      end
    end
  end

  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
    assign slot_pc[k] = r.pc + 32'(8 * k);
    fs2_predecode u_pd (
      .inst(r.inst[k*INST_WIDTH +: INST_WIDTH]),
      .pc(slot_pc[k]),
      .is_cti(cti[k]),
      .br_type(br[k]),
      .is_direct(dir[k]),
      .target(dtgt[k])
    );
    assign cti_v[k] = cti[k];
  end

  always_comb begin
    done = 1'b0;
    rec = 1'b0;
    call = 1'b0;
    rtr = 1'b0;
    hit = 1'b0;
    fs1_taken = 1'b0;
    tgt = '0;
    cpc = '0;
    taken = '0;
    for (int k = 0; k < FETCH_WIDTH; k++)
      fin_tgt[k] = r.target[k*SIZE_PC +: SIZE_PC];
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      hit = r.btb_hit[k];
      fs1_taken = hit & (r.pred[k] | (br[k] != BR_COND));
      if (!done) begin
        if (fs1_taken && !cti[k]) begin
          done = 1'b1;
          rec = 1'b1;
          tgt = slot_pc[k] + 32'd8;
        end else if (fs1_taken && dir[k]
                     && fin_tgt[k] != dtgt[k]) begin
          done = 1'b1;
          rec = 1'b1;
          tgt = dtgt[k];
          taken[k] = 1'b1;
          fin_tgt[k] = dtgt[k];
        end else if (!hit && dir[k]
                     && br[k] != BR_COND) begin
          done = 1'b1;
          rec = 1'b1;
          tgt = dtgt[k];
          taken[k] = 1'b1;
          fin_tgt[k] = dtgt[k];
          if (br[k] == BR_CALL) begin
            call = 1'b1;
            cpc = slot_pc[k] + 32'd8;
          end
        end else if (!hit && cti[k]
                     && br[k] == BR_RET) begin
          done = 1'b1;
          rec = 1'b1;
          rtr = 1'b1;
          tgt = r.ras;
          taken[k] = 1'b1;
          fin_tgt[k] = r.ras;
        end else if (fs1_taken) begin
          done = 1'b1;
          taken[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    live = '0;
    live[0] = 1'b1;
    for (int j = 1; j < FETCH_WIDTH; j++)
      live[j] = live[j-1] & ~taken[j-1];
  end

  assign iv = live & {FETCH_WIDTH{r.valid}};
  assign en = r.valid & ~stall_i & ~reset;

  assign bus.flagRecoverID_o = en & rec;
  assign bus.targetAddrID_o = en ? tgt : '0;
  assign bus.flagCallID_o = en & call;
  assign bus.callPCID_o = en ? cpc : '0;
  assign bus.flagRtrID_o = en & rtr;

  assign bus.fs2Valid_o = r.valid;
  assign bus.instValid_o = iv;
  assign bus.instBundle_o = r.inst;
  assign bus.pc_o = r.pc;
  assign bus.predTaken_o = taken & iv;
  assign bus.isCti_o = cti_v & iv;
  assign bus.ctiCount_o = 3'($countones(cti_v & iv));

  always_comb begin
    bus.predTarget_o = '0;
    bus.brType_o = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (r.valid) begin
        bus.predTarget_o[k*SIZE_PC +: SIZE_PC] = fin_tgt[k];
        bus.brType_o[2*k +: 2] = br[k];
      end
    end
  end

endmodule
